uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   UART transmitter, the TX counterpart of uart_rx: 8N1 frames, LSB first, on o_Tx_Serial.
//   A small byte FIFO decouples the producer (handshake/app logic) from the line rate.
//   Sits beside uart_rx in the FPGA top; output goes to the board TX pin (muxed with handshake TX).
//   Gated by i_Enable (driven from uart_enable) so nothing is sent before a successful handshake.
// PARAMETERS
//   CLKS_PER_BIT  5208  clock cycles per bit (50 MHz / 9600 baud); must be >= 2
//   FIFO_DEPTH    4     byte FIFO entries; power of 2, >= 2
// PORTS
//   i_Clock       in   1                       system clock; all logic on rising edge
//   i_Reset       in   1                       synchronous reset, active-high
//   i_Enable      in   1                       1 = frames may start; 0 = hold FIFO, finish current frame
//   i_Tx_DV       in   1                       write strobe; byte accepted on edge when o_Tx_Ready=1
//   i_Tx_Byte     in   8                       byte to enqueue, sampled with i_Tx_DV
//   o_Tx_Ready    out  1                       FIFO not full (registered)
//   o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1    bytes queued, excluding byte in flight
//   o_Tx_Serial   out  1                       serial line; idle high
//   o_Tx_Active   out  1                       1 from start bit to end of stop bit
//   o_Tx_Done     out  1                       1-cycle pulse on the last cycle of each stop bit
// BEHAVIOUR
//   Reset (i_Reset=1 at an edge): o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1,
//     o_Fifo_Count=0, FIFO pointers 0, FSM=IDLE. Reset mid-frame aborts it: line high next cycle.
//   FSM states: IDLE, START, DATA, STOP. Bit counter 0..CLKS_PER_BIT-1, bit index 0..7.
//   IDLE : line 1. If i_Enable=1 and count>0: pop head into shift reg, -> START.
//   START: line 0 for exactly CLKS_PER_BIT cycles, -> DATA with index 0.
//   DATA : line = shift[index] for CLKS_PER_BIT cycles each; after index 7 -> STOP.
//   STOP : line 1 for CLKS_PER_BIT cycles; o_Tx_Done=1 on final cycle; then:
//          if i_Enable=1 and count>0 pop and -> START (no idle gap), else -> IDLE.
//   Frame = exactly 10*CLKS_PER_BIT cycles; back-to-back frames contiguous.
//   Latency: write at edge N into empty FIFO with FSM IDLE, i_Enable=1 -> pop at edge N+1,
//     o_Tx_Serial=0 and o_Tx_Active=1 from edge N+1.
//   i_Enable falls mid-frame: current frame completes unchanged; next pop waits for i_Enable=1.
//   Writes accepted regardless of i_Enable.
//   FIFO: circular, pointers wrap modulo FIFO_DEPTH; count width holds 0..FIFO_DEPTH.
//   Write when full (o_Tx_Ready=0): byte dropped, FIFO and count unchanged.
//   Same-edge write and pop: both occur, count unchanged; a write when full is still dropped
//     even if a pop occurs that edge (Ready is registered, from pre-edge count).
//   o_Tx_Ready = (count < FIFO_DEPTH) after each edge; o_Tx_Done never asserted outside STOP.
//   Byte in shift register is stable for the whole frame; FIFO writes never alter it.
// TESTING  (CLKS_PER_BIT=4, FIFO_DEPTH=4 in bench)
//   Reset: hold i_Reset 2 cycles -> Serial=1, Ready=1, Count=0, Active=0, Done=0.
//   Single byte 0x55, Enable=1 -> start bit one cycle after write; line 0,1,0,1,0,1,0,1,0,1
//     each held 4 cycles (40 total); Done pulses once at cycle 40; then IDLE, line 1.
//   Burst 0xA5,0x3C,0xFF,0x00,0x81 on consecutive cycles, Enable=1 -> first pops immediately,
//     next 4 queue (Count=4, Ready=0), none dropped; 5 contiguous frames, 5 Done pulses, 200 cycles.
//   Overflow: Enable=0, write 5 bytes -> Count=4, 5th dropped; raise Enable -> exactly 4 frames.
//   Enable drop mid-frame: clear Enable during DATA of byte 0x0F with 0x11 queued -> 0x0F finishes,
//     line stays 1, Count=1; re-enable -> 0x11 starts next cycle.
//   Loopback: o_Tx_Serial -> uart_rx (same CLKS_PER_BIT, enabled); 256 random bytes -> o_Rx_Byte
//     matches each in order; also reset mid-DATA -> line 1 next cycle, Count=0, no Done pulse.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter, LSB first, fed by a small byte FIFO.
// Ports: i_Clock, i_Reset (sync, high), i_Enable (gates frame starts),
//   i_Tx_DV/i_Tx_Byte (write when o_Tx_Ready), o_Fifo_Count (queued bytes),
//   o_Tx_Serial (line, idle high), o_Tx_Active (in frame), o_Tx_Done (stop end).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Enable,
    input  logic                          i_Tx_DV,
    input  logic [7:0]                    i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int NW = $clog2(CLKS_PER_BIT);
    localparam logic [NW-1:0] CNT_MAX = NW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            serial_q, serial_d;
    logic            active_q, active_d;
    logic            done_q, done_d;
    logic            ready_q, ready_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            wr, pop, last, can_pop;

    assign wr      = i_Tx_DV && ready_q;
    assign last    = (cnt_q == CNT_MAX);
    assign can_pop = i_Enable && (count_q != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (can_pop) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                cnt_d = cnt_q + NW'(1);
                if (last) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_q + NW'(1);
                if (last) begin
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                cnt_d = cnt_q + NW'(1);
                if (last) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    // Chain straight into the next start bit: no idle gap.
                    if (can_pop) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line and status are registered from next-state for a clean pin.
        serial_d = 1'b1;
        unique case (state_d)
            IDLE:    serial_d = 1'b1;
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[idx_d];
            STOP:    serial_d = 1'b1;
            default: serial_d = 1'b1;
        endcase
        active_d = (state_d != IDLE);
        done_d   = (state_d == STOP) && (cnt_d == CNT_MAX);

        count_d = count_q;
        unique case ({wr, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d < DEPTH);
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            count_q  <= count_d;
            if (wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Storage needs no reset; only slots behind the pointers are read.
    always_ff @(posedge i_Clock) begin
        if (wr && !i_Reset) begin
            mem_q[wr_ptr_q] <= i_Tx_Byte;
        end
    end

    assign o_Tx_Ready   = ready_q;
    assign o_Fifo_Count = count_q;
    assign o_Tx_Serial  = serial_q;
    assign o_Tx_Active  = active_q;
    assign o_Tx_Done    = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: checks uart_tx_fifo framing, FIFO, enable gating, reset.
// A serial decoder on the line compares received bytes with a queue.
module tb_uart_tx_fifo;

    localparam int CPB = 4;
    localparam int DEP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       dv  = 1'b0;
    logic [7:0] din = 8'h00;
    logic       rdy, ser, act, done;
    logic [2:0] cnt;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Enable    (en),
        .i_Tx_DV     (dv),
        .i_Tx_Byte   (din),
        .o_Tx_Ready  (rdy),
        .o_Fifo_Count(cnt),
        .o_Tx_Serial (ser),
        .o_Tx_Active (act),
        .o_Tx_Done   (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb [$];
    int done_cnt   = 0;
    int act_cycles = 0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line decoder: c=0 is the first cycle of the start bit.
    bit         rx_busy = 0;
    int         rx_c    = 0;
    logic [7:0] rx_sh   = 8'h00;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (rst) begin
            rx_busy = 0;
        end else begin
            if (done === 1'b1) done_cnt++;
            if (act === 1'b1) act_cycles++;
            if (!rx_busy && ser === 1'b0) begin
                rx_busy = 1;
                rx_c    = 0;
                chk("active_at_start", act, 1);
            end else if (rx_busy) begin
                rx_c++;
            end
            if (rx_busy) begin
                if (rx_c == 2) chk("start_bit", ser, 0);
                if (rx_c >= 6 && rx_c <= 34 && rx_c % 4 == 2)
                    rx_sh[(rx_c - 6) / 4] = ser;
                if (rx_c == 38) chk("stop_bit", ser, 1);
                if (rx_c == 39) begin
                    chk("done_pos", done, 1);
                    if (sb.size() == 0) begin
                        chk("sb_nonempty", 0, 1);
                    end else begin
                        exp_b = sb.pop_front();
                        chk("rx_byte", rx_sh, exp_b);
                    end
                    rx_busy = 0;
                end else if (done !== 1'b0) begin
                    chk("done_early", done, 0);
                end
            end else if (done !== 1'b0) begin
                chk("done_idle", done, 0);
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((act || cnt != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", {31'd0, (act || cnt != 0)}, 0);
    endtask

    typedef struct {
        logic       dv;
        logic [7:0] data;
        logic       acc;
        logic [2:0] cnt;
        logic       rdy;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int d0, n;
        logic [7:0] b;
        logic [7:0] burst [5];

        tbl[0] = '{1'b1, 8'h11, 1'b1, 3'd1, 1'b1};
        tbl[1] = '{1'b1, 8'h22, 1'b1, 3'd2, 1'b1};
        tbl[2] = '{1'b1, 8'h33, 1'b1, 3'd3, 1'b1};
        tbl[3] = '{1'b1, 8'h44, 1'b1, 3'd4, 1'b0};
        tbl[4] = '{1'b1, 8'h99, 1'b0, 3'd4, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b0};
        burst  = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};

        // Reset
        rst = 1'b1;
        repeat (2) tick();
        chk("rst_serial", ser, 1);
        chk("rst_ready", rdy, 1);
        chk("rst_count", cnt, 0);
        chk("rst_active", act, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick();

        // Single byte 0x55
        en = 1'b1;
        act_cycles = 0;
        d0 = done_cnt;
        dv = 1'b1; din = 8'h55; sb.push_back(8'h55);
        tick();
        dv = 1'b0;
        chk("single_wr_serial", ser, 1);
        chk("single_wr_count", cnt, 1);
        tick();
        chk("single_start_serial", ser, 0);
        chk("single_start_active", act, 1);
        chk("single_start_count", cnt, 0);
        wait_idle(100);
        chk("single_len", act_cycles, 40);
        chk("single_done", done_cnt - d0, 1);
        chk("single_idle_line", ser, 1);

        // Burst of 5
        act_cycles = 0;
        d0 = done_cnt;
        for (int i = 0; i < 5; i++) begin
            dv = 1'b1; din = burst[i]; sb.push_back(burst[i]);
            tick();
        end
        dv = 1'b0;
        chk("burst_count", cnt, 4);
        chk("burst_ready", rdy, 0);
        wait_idle(300);
        chk("burst_len", act_cycles, 200);
        chk("burst_done", done_cnt - d0, 5);

        // Overflow with enable low, table-driven
        en = 1'b0;
        d0 = done_cnt;
        for (int i = 0; i < 6; i++) begin
            dv = tbl[i].dv; din = tbl[i].data;
            if (tbl[i].acc) sb.push_back(tbl[i].data);
            tick();
            chk($sformatf("ovf_cnt_%0d", i), cnt, tbl[i].cnt);
            chk($sformatf("ovf_rdy_%0d", i), rdy, tbl[i].rdy);
            chk($sformatf("ovf_line_%0d", i), ser, 1);
        end
        dv = 1'b0;
        en = 1'b1;
        wait_idle(300);
        chk("ovf_frames", done_cnt - d0, 4);
        chk("ovf_sb_empty", sb.size(), 0);

        // Enable drop mid-frame
        d0 = done_cnt;
        dv = 1'b1; din = 8'h0F; sb.push_back(8'h0F);
        tick();
        din = 8'h11; sb.push_back(8'h11);
        tick();
        dv = 1'b0;
        chk("endrop_queued", cnt, 1);
        repeat (10) tick();
        en = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 60) begin
            tick();
            n++;
        end
        chk("endrop_first_done", done_cnt - d0, 1);
        repeat (6) tick();
        chk("endrop_line", ser, 1);
        chk("endrop_active", act, 0);
        chk("endrop_count", cnt, 1);
        en = 1'b1;
        tick();
        chk("reen_serial", ser, 0);
        chk("reen_active", act, 1);
        chk("reen_count", cnt, 0);
        wait_idle(100);
        chk("endrop_done", done_cnt - d0, 2);

        // Loopback of 256 random bytes
        d0 = done_cnt;
        for (int i = 0; i < 256; i++) begin
            n = 0;
            dv = 1'b0;
            while (!rdy && n < 200) begin
                tick();
                n++;
            end
            if (!rdy) chk("lb_ready_timeout", rdy, 1);
            b = 8'($urandom);
            dv = 1'b1; din = b; sb.push_back(b);
            tick();
        end
        dv = 1'b0;
        wait_idle(500);
        chk("lb_frames", done_cnt - d0, 256);
        chk("lb_sb_empty", sb.size(), 0);

        // Reset mid-DATA
        dv = 1'b1; din = 8'h5A; sb.push_back(8'h5A);
        tick();
        dv = 1'b0;
        repeat (12) tick();
        chk("mid_active", act, 1);
        d0 = done_cnt;
        rst = 1'b1;
        sb.delete();
        tick();
        chk("mid_rst_serial", ser, 1);
        chk("mid_rst_count", cnt, 0);
        chk("mid_rst_active", act, 0);
        chk("mid_rst_ready", rdy, 1);
        rst = 1'b0;
        repeat (50) tick();
        chk("mid_rst_no_done", done_cnt - d0, 0);
        chk("mid_rst_line", ser, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
